// File: rtl/instr_fetch_unit_if.sv
// Bundle of the fetch unit's memory, redirect and decoder-facing signals.
// Every valid/ready pair transfers on a rising edge where both are 1; valid and its payload hold until then.
interface instr_fetch_unit_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect;
    logic [31:0] redirect_target;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] Instr;
    logic [31:0] instr_pc;
    logic        flushing;
    logic [1:0]  fsm_state;

    modport master (
        output imem_req_valid, imem_req_addr, instr_valid, Instr, instr_pc, flushing, fsm_state,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect, redirect_target, instr_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, instr_valid, Instr, instr_pc, flushing, fsm_state,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect, redirect_target, instr_ready
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: owns the fetch PC, issues credit-limited word requests,
// tags in-order responses with their PC in a prefetch FIFO and flushes on branch redirect.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC        = 32'h0000_0000,
    parameter int          DEPTH           = 4,
    parameter int          MAX_OUTSTANDING = 2
) (
    input  logic                clk,
    input  logic                reset,
    instr_fetch_unit_if.master  io_bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam int TW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    localparam logic [31:0]   DEPTH_U  = DEPTH;
    localparam logic [31:0]   MAX_U    = MAX_OUTSTANDING;
    localparam logic [CW-1:0] ONE_C    = 1;
    localparam logic [OW-1:0] ONE_O    = 1;
    localparam logic [PW-1:0] ONE_P    = 1;
    localparam logic [TW-1:0] ONE_T    = 1;
    localparam logic [TW-1:0] TAG_LAST = TW'(MAX_OUTSTANDING - 1);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_STALL = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_next;
    logic [31:0]   r_fetch_pc;
    logic [31:0]   r_fifo_instr [DEPTH];
    logic [31:0]   r_fifo_pc    [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic [OW-1:0] r_outstanding;
    logic [OW-1:0] r_drop_cnt;
    logic [31:0]   r_tag [MAX_OUTSTANDING];
    logic [TW-1:0] r_tag_wr;
    logic [TW-1:0] r_tag_rd;

    logic          w_credit;
    logic          w_credit_next;
    logic          w_req_valid;
    logic          w_accept;
    logic          w_rsp;
    logic          w_redirect;
    logic          w_drop_rsp;
    logic          w_push;
    logic          w_pop;
    logic [OW-1:0] w_out_next;
    logic [OW-1:0] w_drop_next;
    logic [CW-1:0] w_count_next;

    // Reserving a FIFO slot for every in-flight request guarantees a response always has room.
    assign w_credit = (32'(r_count) + 32'(r_outstanding) < DEPTH_U) && (32'(r_outstanding) < MAX_U);

    assign w_redirect  = io_bus.redirect;
    assign w_req_valid = reset & ~w_redirect & w_credit;
    assign w_accept    = w_req_valid & io_bus.imem_req_ready;
    assign w_rsp       = io_bus.imem_rsp_valid;
    assign w_drop_rsp  = w_rsp & (w_redirect | (r_drop_cnt != '0));
    assign w_push      = w_rsp & ~w_drop_rsp;
    assign w_pop       = (r_count != '0) & io_bus.instr_ready & ~w_redirect;

    always_comb begin
        w_out_next   = r_outstanding;
        w_drop_next  = r_drop_cnt;
        w_count_next = r_count;
        if (w_accept) w_out_next = w_out_next + ONE_O;
        if (w_rsp)    w_out_next = w_out_next - ONE_O;
        if (w_redirect) begin
            // Everything still in flight belongs to the abandoned path, except a word landing right now.
            w_drop_next  = w_rsp ? (r_outstanding - ONE_O) : r_outstanding;
            w_count_next = '0;
        end else begin
            if (w_rsp && (r_drop_cnt != '0)) w_drop_next = r_drop_cnt - ONE_O;
            if (w_push && !w_pop)            w_count_next = r_count + ONE_C;
            else if (!w_push && w_pop)       w_count_next = r_count - ONE_C;
        end
    end

    assign w_credit_next = (32'(w_count_next) + 32'(w_out_next) < DEPTH_U) && (32'(w_out_next) < MAX_U);

    always_comb begin
        w_state_next = S_FETCH;
        if (w_drop_next != '0)   w_state_next = S_FLUSH;
        else if (!w_credit_next) w_state_next = S_STALL;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_FETCH;
        else        r_state <= w_state_next;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_fetch_pc    <= RESET_PC;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= '0;
            r_outstanding <= '0;
            r_drop_cnt    <= '0;
            r_tag_wr      <= '0;
            r_tag_rd      <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_fifo_instr[i] <= '0;
                r_fifo_pc[i]    <= '0;
            end
            for (int i = 0; i < MAX_OUTSTANDING; i++) r_tag[i] <= '0;
        end else begin
            r_outstanding <= w_out_next;
            r_drop_cnt    <= w_drop_next;
            r_count       <= w_count_next;

            if (w_redirect)    r_fetch_pc <= {io_bus.redirect_target[31:2], 2'b00};
            else if (w_accept) r_fetch_pc <= r_fetch_pc + 32'd4;

            // The tag queue tracks every in-flight request, dropped or not, so it stays aligned.
            if (w_accept) begin
                r_tag[r_tag_wr] <= r_fetch_pc;
                r_tag_wr        <= (r_tag_wr == TAG_LAST) ? '0 : r_tag_wr + ONE_T;
            end
            if (w_rsp) r_tag_rd <= (r_tag_rd == TAG_LAST) ? '0 : r_tag_rd + ONE_T;

            if (w_redirect) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
            end else begin
                if (w_push) begin
                    r_fifo_instr[r_wr_ptr] <= io_bus.imem_rsp_data;
                    r_fifo_pc[r_wr_ptr]    <= r_tag[r_tag_rd];
                    r_wr_ptr               <= r_wr_ptr + ONE_P;
                end
                if (w_pop) r_rd_ptr <= r_rd_ptr + ONE_P;
            end
        end
    end

    assign io_bus.imem_req_valid = w_req_valid;
    assign io_bus.imem_req_addr  = reset ? r_fetch_pc : 32'd0;
    assign io_bus.instr_valid    = (r_count != '0);
    assign io_bus.Instr          = r_fifo_instr[r_rd_ptr];
    assign io_bus.instr_pc       = r_fifo_pc[r_rd_ptr];
    assign io_bus.flushing       = (r_drop_cnt != '0);
    assign io_bus.fsm_state      = r_state;

    // Any of these firing means the credit scheme or the memory's response contract broke.
    a_count_bound: assert property (@(posedge clk) disable iff (!reset) r_count <= CW'(DEPTH));
    a_out_bound:   assert property (@(posedge clk) disable iff (!reset) r_outstanding <= OW'(MAX_OUTSTANDING));
    a_rsp_owed:    assert property (@(posedge clk) disable iff (!reset) !(w_rsp && (r_outstanding == '0)));
    a_push_room:   assert property (@(posedge clk) disable iff (!reset) !(w_push && (r_count == CW'(DEPTH))));
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: behavioural instruction memory with programmable
// latency, scoreboard of fetched PCs, and a table of redirect-target vectors.
module tb_instr_fetch_unit;
    localparam logic [31:0] ST_FETCH = 32'd0;
    localparam logic [31:0] ST_STALL = 32'd1;
    localparam logic [31:0] ST_FLUSH = 32'd2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    instr_fetch_unit_if bus();

    instr_fetch_unit #(
        .RESET_PC(32'h0000_0000),
        .DEPTH(4),
        .MAX_OUTSTANDING(2)
    ) dut (
        .clk(clk),
        .reset(reset),
        .io_bus(bus)
    );

    typedef struct {
        logic [31:0] target;
        logic [31:0] pc0;
        logic [31:0] pc1;
        logic [31:0] pc2;
    } redir_vec_t;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          mem_lat  = 1;
    int          last_due = 0;
    int          flush_cycles = 0;
    logic        last_rsp;
    logic        drv_ready, drv_ir, drv_redirect;
    logic [31:0] drv_target;
    logic [31:0] pend_addr[$];
    int          pend_due[$];
    logic [31:0] got_q[$];
    logic [31:0] exp_q[$];
    redir_vec_t  vecs[5];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hE1A0_0000;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic chk_zero(input string name);
        check({name, "_req_valid"},   {31'd0, bus.imem_req_valid}, 32'd0);
        check({name, "_req_addr"},    bus.imem_req_addr, 32'd0);
        check({name, "_instr_valid"}, {31'd0, bus.instr_valid}, 32'd0);
        check({name, "_Instr"},       bus.Instr, 32'd0);
        check({name, "_instr_pc"},    bus.instr_pc, 32'd0);
        check({name, "_flushing"},    {31'd0, bus.flushing}, 32'd0);
    endtask

    task automatic clear_inputs();
        bus.imem_req_ready  = 1'b0;
        bus.imem_rsp_valid  = 1'b0;
        bus.imem_rsp_data   = 32'd0;
        bus.redirect        = 1'b0;
        bus.redirect_target = 32'd0;
        bus.instr_ready     = 1'b0;
        pend_addr.delete();
        pend_due.delete();
        got_q.delete();
        exp_q.delete();
        last_due = cyc;
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        clear_inputs();
        drv_ready = 1'b1; drv_ir = 1'b1; drv_redirect = 1'b0; drv_target = 32'd0; mem_lat = 1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk_zero($sformatf("reset%0d", i));
        end
        reset = 1'b1;
        #1;
    endtask

    // One clock: drive inputs, model memory, log accepted requests and consumed instructions.
    task automatic step();
        int due;
        bus.imem_req_ready  = drv_ready;
        bus.instr_ready     = drv_ir;
        bus.redirect        = drv_redirect;
        bus.redirect_target = drv_target;
        bus.imem_rsp_valid  = 1'b0;
        if (pend_addr.size() > 0 && pend_due[0] <= cyc) begin
            bus.imem_rsp_valid = 1'b1;
            bus.imem_rsp_data  = mem_word(pend_addr[0]);
            void'(pend_addr.pop_front());
            void'(pend_due.pop_front());
        end
        last_rsp = bus.imem_rsp_valid;
        #1;
        if (bus.imem_req_valid && bus.imem_req_ready) begin
            due = cyc + mem_lat;
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            pend_addr.push_back(bus.imem_req_addr);
            pend_due.push_back(due);
        end
        if (bus.instr_valid && bus.instr_ready && !bus.redirect) begin
            got_q.push_back(bus.instr_pc);
            check("instr_word", bus.Instr, mem_word(bus.instr_pc));
        end
        if (bus.flushing) flush_cycles++;
        drv_redirect = 1'b0;
        @(posedge clk); #1;
        bus.redirect       = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        #1;
        cyc++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic score(input string name);
        for (int i = 0; i < exp_q.size(); i++)
            check($sformatf("%s[%0d]", name, i), (i < got_q.size()) ? got_q[i] : 32'hDEAD_BEEF, exp_q[i]);
        exp_q.delete();
        got_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{target: 32'h0000_0103, pc0: 32'h0000_0100, pc1: 32'h0000_0104, pc2: 32'h0000_0108};
        vecs[1] = '{target: 32'hFFFF_FFFC, pc0: 32'hFFFF_FFFC, pc1: 32'h0000_0000, pc2: 32'h0000_0004};
        vecs[2] = '{target: 32'h0000_0002, pc0: 32'h0000_0000, pc1: 32'h0000_0004, pc2: 32'h0000_0008};
        vecs[3] = '{target: 32'h7FFF_FFFF, pc0: 32'h7FFF_FFFC, pc1: 32'h8000_0000, pc2: 32'h8000_0004};
        vecs[4] = '{target: 32'h0000_1000, pc0: 32'h0000_1000, pc1: 32'h0000_1004, pc2: 32'h0000_1008};

        // Reset values and first request after release
        apply_reset();
        check("first_req_valid", {31'd0, bus.imem_req_valid}, 32'd1);
        check("first_req_addr",  bus.imem_req_addr, 32'h0);
        check("first_state",     {30'd0, bus.fsm_state}, ST_FETCH);

        // Steady stream, latency 1: one instruction per cycle from the third cycle on
        run(20);
        check("stream_count", got_q.size(), 32'd18);
        for (int i = 0; i < 18; i++) exp_q.push_back(32'(i * 4));
        score("stream_pc");

        // Decoder stalled: FIFO fills to 4 and requests stop
        apply_reset();
        drv_ir = 1'b0;
        run(20);
        check("stall_instr_valid", {31'd0, bus.instr_valid}, 32'd1);
        check("stall_req_valid",   {31'd0, bus.imem_req_valid}, 32'd0);
        check("stall_state",       {30'd0, bus.fsm_state}, ST_STALL);
        check("stall_head_pc",     bus.instr_pc, 32'h0);
        check("stall_no_pops",     got_q.size(), 32'd0);
        drv_ir = 1'b1;
        run(8);
        exp_q = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10};
        score("drain_pc");

        // Redirect with two requests in flight at latency 3
        apply_reset();
        mem_lat = 3;
        run(2);
        flush_cycles = 0;
        drv_redirect = 1'b1;
        drv_target   = 32'h0000_0100;
        step();
        check("flush_flag",  {31'd0, bus.flushing}, 32'd1);
        check("flush_state", {30'd0, bus.fsm_state}, ST_FLUSH);
        run(15);
        check("flush_cycles", flush_cycles, 32'd2);
        exp_q = '{32'h100, 32'h104, 32'h108};
        score("post_flush_pc");

        // Table of redirect targets: alignment and address wrap
        apply_reset();
        run(8);
        for (int v = 0; v < 5; v++) begin
            got_q.delete();
            drv_redirect = 1'b1;
            drv_target   = vecs[v].target;
            step();
            check($sformatf("vec%0d_req_valid", v), {31'd0, bus.imem_req_valid}, 32'd1);
            check($sformatf("vec%0d_req_addr", v),  bus.imem_req_addr, vecs[v].pc0);
            run(8);
            exp_q = '{vecs[v].pc0, vecs[v].pc1, vecs[v].pc2};
            score($sformatf("vec%0d_pc", v));
        end

        // Redirect in the same cycle as a response and a decoder pop
        apply_reset();
        mem_lat = 2;
        drv_ir  = 1'b0;
        run(5);
        check("pre6_instr_valid", {31'd0, bus.instr_valid}, 32'd1);
        flush_cycles = 0;
        drv_ir       = 1'b1;
        drv_redirect = 1'b1;
        drv_target   = 32'h0000_0200;
        step();
        check("c6_rsp_coincident", {31'd0, last_rsp}, 32'd1);
        check("c6_instr_valid",    {31'd0, bus.instr_valid}, 32'd0);
        check("c6_flushing",       {31'd0, bus.flushing}, 32'd1);
        check("c6_state",          {30'd0, bus.fsm_state}, ST_FLUSH);
        run(10);
        check("c6_flush_cycles", flush_cycles, 32'd1);
        exp_q = '{32'h200, 32'h204};
        score("c6_pc");

        // Asynchronous reset in the middle of a stream
        apply_reset();
        run(6);
        #2;
        reset = 1'b0;
        #1;
        chk_zero("async");
        clear_inputs();
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        check("restart_req_valid", {31'd0, bus.imem_req_valid}, 32'd1);
        check("restart_req_addr",  bus.imem_req_addr, 32'h0);
        run(10);
        exp_q = '{32'h0, 32'h4, 32'h8};
        score("restart_pc");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
